// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the MIPS control logic: FSM state encodings (also
// exported on the debug port), opcode/funct constants, instruction classes
// and the pc_sel / wb_sel mux codes driven into the datapath.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,  // register-writing ALU op, goes through WB
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,  // beq/bne/j/jr: retire in EXEC, no register write
    CLS_JAL     = 3'd4,  // retire in EXEC with link write
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] WB_RESULT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_LINK   = 2'd2;

endpackage

// File: rtl/mips_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_ctrl_decode
// Pure combinational instruction decode shared by control units.
// Ports:
//   op, funct  : instruction fields Ins[31:26], Ins[5:0]
//   zero       : EX equality flag, resolves beq/bne direction
//   cls        : instruction class
//   pc_sel     : next-PC source for instructions that redirect or retire
//   wb_sel     : register write-back source
//   legal      : opcode is known (halt included)
// -----------------------------------------------------------------------------
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  input  logic         zero,
  output instr_class_e cls,
  output logic [1:0]   pc_sel,
  output logic [1:0]   wb_sel,
  output logic         legal
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    pc_sel = PC_NEXT;
    wb_sel = WB_RESULT;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          cls    = CLS_BRANCH;
          pc_sel = PC_REG;
        end else begin
          cls = CLS_ALU;
        end
      end
      OP_ADDI, OP_ORI, OP_SLTI: cls = CLS_ALU;
      OP_LW: begin
        cls    = CLS_LOAD;
        wb_sel = WB_MEM;
      end
      OP_SW:  cls = CLS_STORE;
      OP_BEQ: begin
        cls    = CLS_BRANCH;
        pc_sel = zero ? PC_BRANCH : PC_NEXT;
      end
      OP_BNE: begin
        cls    = CLS_BRANCH;
        pc_sel = zero ? PC_NEXT : PC_BRANCH;
      end
      OP_J: begin
        cls    = CLS_BRANCH;
        pc_sel = PC_JUMP;
      end
      OP_JAL: begin
        cls    = CLS_JAL;
        pc_sel = PC_JUMP;
        wb_sel = WB_LINK;
      end
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILLEGAL;
    endcase
    legal = (cls != CLS_ILLEGAL);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Main control FSM of the multicycle MIPS core. Sequences LOAD, FETCH, DECODE,
// EXEC, MEM and WB, handshakes with wait-state memories and counts retired
// instructions.
// Ports:
//   CLK, RST        : clock (rising edge), asynchronous active-low reset
//   WE              : instruction-memory load in progress, blocks fetching
//   op, funct, zero : instruction fields and EX equality flag
//   i_ack, d_ack    : instruction / data memory completion
//   i_req, ir_we    : fetch request, instruction register load
//   pc_we, pc_sel   : PC load strobe and next-PC source
//   d_req, d_wr     : data memory request and direction (1 = store)
//   reg_we, wb_sel  : register file write strobe and source
//   state           : current state (debug)
//   halted, err     : sticky halt / trap indications
//   retired         : retired-instruction count, wraps
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             i_ack,
  input  logic             d_ack,
  output logic             i_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             d_req,
  output logic             d_wr,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  instr_class_e       cls;
  logic [1:0]         dec_pc_sel;
  logic [1:0]         dec_wb_sel;
  logic               dec_legal;
  logic               tmo_hit;
  logic               halt_retire;
  state_e             done_state;

  mips_ctrl_decode u_decode (
    .op     (op),
    .funct  (funct),
    .zero   (zero),
    .cls    (cls),
    .pc_sel (dec_pc_sel),
    .wb_sel (dec_wb_sel),
    .legal  (dec_legal)
  );

  // Last allowed wait cycle: no ack now means the memory is considered dead.
  assign tmo_hit = (tmo_q == TMO_LAST);

  // A completing instruction parks the core in LOAD if a memory load started.
  assign done_state = WE ? ST_LOAD : ST_FETCH;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_LOAD;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_req       = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_NEXT;
    d_req       = 1'b0;
    d_wr        = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_RESULT;
    halt_retire = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (!WE) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        i_req = 1'b1;
        if (i_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_HALT) begin
          state_d     = ST_HALT;
          halt_retire = 1'b1;
        end else if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = dec_pc_sel;
            state_d = done_state;
          end
          CLS_JAL: begin
            pc_we   = 1'b1;
            pc_sel  = dec_pc_sel;
            reg_we  = 1'b1;
            wb_sel  = dec_wb_sel;
            state_d = done_state;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_ALU:             state_d = ST_WB;
          default:             state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        d_req = 1'b1;
        d_wr  = (cls == CLS_STORE);
        if (d_ack) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_NEXT;
            state_d = done_state;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = dec_wb_sel;
        pc_we   = 1'b1;
        pc_sel  = PC_NEXT;
        state_d = done_state;
      end
      ST_HALT, ST_TRAP: state_d = state_q;
      default:          state_d = ST_TRAP;
    endcase

    // Wait counter restarts on every state change, so entry to FETCH/MEM sees 0.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    retired_d = retired_q + CNT_W'(pc_we | halt_retire);
  end

  assign state   = state_q;
  assign halted  = (state_q == ST_HALT);
  assign err     = (state_q == ST_TRAP);
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             WE = 1'b1;
  logic [5:0]       op = 6'h00;
  logic [5:0]       funct = 6'h20;
  logic             zero = 1'b0;
  logic             i_ack = 1'b0;
  logic             d_ack = 1'b0;
  logic             i_req, ir_we, pc_we, d_req, d_wr, reg_we, halted, err;
  logic [1:0]       pc_sel, wb_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  mips_multicycle_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .op(op), .funct(funct), .zero(zero),
    .i_ack(i_ack), .d_ack(d_ack), .i_req(i_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .d_req(d_req), .d_wr(d_wr), .reg_we(reg_we), .wb_sel(wb_sel),
    .state(state), .halted(halted), .err(err), .retired(retired)
  );

  always #5 CLK = ~CLK;

  // One expected clock cycle: stimulus to apply and the outputs it must show.
  typedef struct {
    logic        iack;
    logic        dack;
    logic        we;
    logic [14:0] v;
    bit          retire;
  } cyc_t;

  cyc_t             expq[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_ret  = '0;

  // Expected output vector: state, i_req, ir_we, pc_we, d_req, reg_we,
  // pc_sel (meaningful with pc_we), d_wr (with d_req), wb_sel (with reg_we), halted, err.
  function automatic logic [14:0] mk(int st, bit ireq = 0, bit irwe = 0, bit pcwe = 0,
                                     int pcsel = 0, bit dreq = 0, bit dwr = 0,
                                     bit regwe = 0, int wbsel = 0, bit hlt = 0, bit er = 0);
    logic [2:0] s3;
    logic [1:0] p2, w2;
    s3 = st[2:0];
    p2 = pcsel[1:0];
    w2 = wbsel[1:0];
    return {s3, ireq, irwe, pcwe, dreq, regwe, p2, dwr, w2, hlt, er};
  endfunction

  function automatic logic [14:0] obs();
    return {state, i_req, ir_we, pc_we, d_req, reg_we,
            pc_we ? pc_sel : 2'b00, d_req ? d_wr : 1'b0,
            reg_we ? wb_sel : 2'b00, halted, err};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic push(logic ia, logic da, logic w, logic [14:0] v, bit r);
    cyc_t c;
    c.iack = ia; c.dack = da; c.we = w; c.v = v; c.retire = r;
    expq.push_back(c);
  endtask

  // Instruction-level model: the phase sequence each instruction must walk
  // through given its opcode and the memory wait counts.
  task automatic model_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int iw, input int dw, input logic w);
    int ps;
    bit st;
    for (int k = 0; k < iw; k++) push(1'b0, rb(), w, mk(1, 1), 0);
    push(1'b1, rb(), w, mk(1, 1, 1), 0);
    push(rb(), rb(), w, mk(2), 0);
    if ((o == 6'h00 && f == 6'h08) || o == 6'h04 || o == 6'h05 || o == 6'h02) begin
      if (o == 6'h00)      ps = 3;
      else if (o == 6'h02) ps = 2;
      else if (o == 6'h04) ps = z ? 1 : 0;
      else                 ps = z ? 0 : 1;
      push(rb(), rb(), w, mk(3, 0, 0, 1, ps), 1);
    end else if (o == 6'h03) begin
      push(rb(), rb(), w, mk(3, 0, 0, 1, 2, 0, 0, 1, 2), 1);
    end else if (o == 6'h23 || o == 6'h2B) begin
      st = (o == 6'h2B);
      push(rb(), rb(), w, mk(3), 0);
      for (int k = 0; k < dw; k++) push(rb(), 1'b0, w, mk(4, 0, 0, 0, 0, 1, st), 0);
      if (st) begin
        push(rb(), 1'b1, w, mk(4, 0, 0, 1, 0, 1, 1), 1);
      end else begin
        push(rb(), 1'b1, w, mk(4, 0, 0, 0, 0, 1, 0), 0);
        push(rb(), rb(), w, mk(5, 0, 0, 1, 0, 0, 0, 1, 1), 1);
      end
    end else begin
      push(rb(), rb(), w, mk(3), 0);
      push(rb(), rb(), w, mk(5, 0, 0, 1, 0, 0, 0, 1, 0), 1);
    end
  endtask

  task automatic start_core();
    @(negedge CLK);
    RST = 1'b0; WE = 1'b0; i_ack = 1'b0; d_ack = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    exp_ret = '0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    #2 RST = 1'b0; WE = 1'b1;
    #1;
    n_checks++;
    if (obs() !== mk(0) || retired !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%h ret=%0d, want v=%h ret=0", obs(), retired, mk(0));
    end
    @(negedge CLK); RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1; i_ack = rb(); d_ack = rb();
      @(negedge CLK);
      n_checks++;
      if (obs() !== mk(0)) begin
        n_fail++;
        $display("FAIL load_hold: got v=%h, want v=%h", obs(), mk(0));
      end
    end
    @(posedge CLK); #1; WE = 1'b0; i_ack = 1'b1; d_ack = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (obs() !== mk(0)) begin
      n_fail++;
      $display("FAIL load_release: got v=%h, want v=%h", obs(), mk(0));
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_checks++;
    if (obs() !== mk(1, 1, 1)) begin
      n_fail++;
      $display("FAIL load_to_fetch: got v=%h, want v=%h", obs(), mk(1, 1, 1));
    end
    @(posedge CLK); #1; i_ack = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (obs() !== mk(2)) begin
      n_fail++;
      $display("FAIL fetch_to_decode: got v=%h, want v=%h", obs(), mk(2));
    end
  endtask

  task automatic test_alu();
    logic [5:0] ops[5] = '{6'h00, 6'h08, 6'h0D, 6'h0A, 6'h00};
    logic [5:0] fns[5] = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h2A};
    cyc_t c;
    start_core();
    for (int i = 0; i < 5; i++) begin
      op = ops[i]; funct = fns[i]; zero = rb();
      model_instr(ops[i], fns[i], zero, 0, 0, 1'b0);
      while (expq.size() > 0) begin
        c = expq.pop_front();
        i_ack = c.iack; d_ack = c.dack; WE = c.we;
        @(negedge CLK);
        n_checks++;
        if (obs() !== c.v || retired !== exp_ret) begin
          n_fail++;
          $display("FAIL alu op=%h: got v=%h ret=%0d, want v=%h ret=%0d", op, obs(), retired, c.v, exp_ret);
        end
        if (c.retire) exp_ret++;
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    cyc_t c;
    int   dreq_cycles = 0, total = 0;
    bit   seen_pc = 0;
    start_core();
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    model_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
    while (expq.size() > 0) begin
      c = expq.pop_front();
      i_ack = c.iack; d_ack = c.dack; WE = c.we;
      @(negedge CLK);
      n_checks++;
      if (obs() !== c.v || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL lw_wait cyc: got v=%h ret=%0d, want v=%h ret=%0d", obs(), retired, c.v, exp_ret);
      end
      if (d_req) dreq_cycles++;
      if (!seen_pc) total++;
      if (pc_we) seen_pc = 1;
      if (c.retire) exp_ret++;
      @(posedge CLK); #1;
    end
    n_checks++;
    if (dreq_cycles != 4 || total != 8) begin
      n_fail++;
      $display("FAIL lw_latency: got d_req=%0d total=%0d, want d_req=4 total=8", dreq_cycles, total);
    end
  endtask

  task automatic test_branches();
    cyc_t c;
    start_core();
    for (int i = 0; i < 2; i++) begin
      op = 6'h04; funct = 6'h00; zero = (i == 0);
      model_instr(6'h04, 6'h00, zero, 0, 0, 1'b0);
      while (expq.size() > 0) begin
        c = expq.pop_front();
        i_ack = c.iack; d_ack = c.dack; WE = c.we;
        @(negedge CLK);
        n_checks++;
        if (obs() !== c.v || retired !== exp_ret) begin
          n_fail++;
          $display("FAIL beq zero=%0b: got v=%h ret=%0d, want v=%h ret=%0d", zero, obs(), retired, c.v, exp_ret);
        end
        if (c.retire) exp_ret++;
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                            6'h02, 6'h03, 6'h08, 6'h0D, 6'h0A};
    cyc_t c;
    int   idx;
    start_core();
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(10);
      op = ops[idx];
      funct = 6'($urandom_range(63));
      if (idx == 1) funct = 6'h08;
      else if (idx == 0 && funct == 6'h08) funct = 6'h20;
      zero = rb();
      model_instr(op, funct, zero, $urandom_range(3), $urandom_range(3), 1'b0);
      while (expq.size() > 0) begin
        c = expq.pop_front();
        i_ack = c.iack; d_ack = c.dack; WE = c.we;
        @(negedge CLK);
        n_checks++;
        if (obs() !== c.v || retired !== exp_ret) begin
          n_fail++;
          $display("FAIL random op=%h fn=%h: got v=%h ret=%0d, want v=%h ret=%0d", op, funct, obs(), retired, c.v, exp_ret);
        end
        if (c.retire) exp_ret++;
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_we_reentry();
    cyc_t c;
    start_core();
    op = 6'h00; funct = 6'h20; zero = 1'b0;
    model_instr(6'h00, 6'h20, 1'b0, 1, 0, 1'b1);
    for (int k = 0; k < 3; k++) push(rb(), rb(), 1'b1, mk(0), 0);
    push(1'b0, 1'b0, 1'b0, mk(0), 0);
    model_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    while (expq.size() > 0) begin
      c = expq.pop_front();
      i_ack = c.iack; d_ack = c.dack; WE = c.we;
      @(negedge CLK);
      n_checks++;
      if (obs() !== c.v || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL we_reentry: got v=%h ret=%0d, want v=%h ret=%0d", obs(), retired, c.v, exp_ret);
      end
      if (c.retire) exp_ret++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_sticky(input logic [5:0] o);
    logic [14:0] want;
    bit          is_halt;
    is_halt = (o == 6'h3F);
    start_core();
    op = o; funct = 6'h00;
    i_ack = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (obs() !== mk(1, 1, 1)) begin
      n_fail++;
      $display("FAIL sticky_fetch op=%h: got v=%h, want v=%h", o, obs(), mk(1, 1, 1));
    end
    @(posedge CLK); #1; i_ack = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (obs() !== mk(2)) begin
      n_fail++;
      $display("FAIL sticky_decode op=%h: got v=%h, want v=%h", o, obs(), mk(2));
    end
    if (is_halt) exp_ret++;
    want = is_halt ? mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0) : mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1; i_ack = rb(); d_ack = rb(); WE = rb();
      @(negedge CLK);
      n_checks++;
      if (obs() !== want || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL sticky op=%h: got v=%h ret=%0d, want v=%h ret=%0d", o, obs(), retired, want, exp_ret);
      end
    end
    @(posedge CLK); #2; RST = 1'b0;
    #1;
    n_checks++;
    if (obs() !== mk(0) || retired !== '0) begin
      n_fail++;
      $display("FAIL async_reset op=%h: got v=%h ret=%0d, want v=%h ret=0", o, obs(), retired, mk(0));
    end
    @(negedge CLK); RST = 1'b1; WE = 1'b0; i_ack = 1'b0; d_ack = 1'b0;
  endtask

  task automatic test_timeout();
    cyc_t        c;
    logic [14:0] trap_v;
    trap_v = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    start_core();
    op = 6'h00; funct = 6'h20;
    for (int k = 0; k < ACK_TIMEOUT + 4; k++) begin
      i_ack = 1'b0; d_ack = rb();
      @(negedge CLK);
      n_checks++;
      if (obs() !== ((k < ACK_TIMEOUT) ? mk(1, 1) : trap_v)) begin
        n_fail++;
        $display("FAIL i_timeout cyc=%0d: got v=%h, want v=%h", k, obs(), (k < ACK_TIMEOUT) ? mk(1, 1) : trap_v);
      end
      @(posedge CLK); #1;
    end
    start_core();
    op = 6'h23; funct = 6'h00;
    push(1'b1, 1'b0, 1'b0, mk(1, 1, 1), 0);
    push(1'b0, 1'b0, 1'b0, mk(2), 0);
    push(1'b0, 1'b0, 1'b0, mk(3), 0);
    for (int k = 0; k < ACK_TIMEOUT; k++) push(rb(), 1'b0, 1'b0, mk(4, 0, 0, 0, 0, 1, 0), 0);
    for (int k = 0; k < 3; k++) push(rb(), rb(), 1'b0, trap_v, 0);
    while (expq.size() > 0) begin
      c = expq.pop_front();
      i_ack = c.iack; d_ack = c.dack; WE = c.we;
      @(negedge CLK);
      n_checks++;
      if (obs() !== c.v || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL d_timeout: got v=%h ret=%0d, want v=%h ret=%0d", obs(), retired, c.v, exp_ret);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_branches();
    test_sticky(6'h3F);
    test_sticky(6'h3E);
    test_timeout();
    test_we_reentry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM that sequences the MIPS datapath through the FETCH, DECODE, EXEC, MEM and WB phases over several clocks.
- Generates per-phase enables for the PC, instruction register, register file and data memory.
- Handshakes with instruction and data memories that may take wait states.
- Sits beside the IF/ID/EX/MA datapath. Holds the core idle while instruction memory is being loaded through WE.

Parameters:
- ACK_TIMEOUT, 16, maximum cycles waiting for i_ack/d_ack before entering TRAP.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- WE  in  1  instruction-memory load in progress; core must not fetch while high.
- op  in  6  Ins[31:26] from the instruction register.
- funct  in  6  Ins[5:0] from the instruction register.
- zero  in  1  EX equality flag (Rdata1 == Rdata2).
- i_ack  in  1  instruction memory read done; Ins valid this cycle.
- d_ack  in  1  data memory access done.
- i_req  out  1  instruction fetch request.
- ir_we  out  1  latch Ins into the instruction register.
- pc_we  out  1  load newPC into PC.
- pc_sel  out  2  0 = nextPC (PC+4), 1 = branch target, 2 = jump target, 3 = Rdata1 (jr).
- d_req  out  1  data memory request.
- d_wr  out  1  1 = store, 0 = load; valid while d_req is high.
- reg_we  out  1  register file write strobe.
- wb_sel  out  2  0 = Result, 1 = memory data, 2 = nextPC (jal).
- state  out  3  current state encoding, for debug.
- halted  out  1  halt instruction retired.
- err  out  1  illegal opcode or timeout.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (RST=0, asynchronous): state=LOAD, all strobes 0, pc_sel=0, wb_sel=0, halted=0, err=0, retired=0.
- States:
  - LOAD=0: stays while WE=1. Goes to FETCH on the first cycle WE=0.
  - FETCH=1: i_req=1 held until i_ack. On i_ack: ir_we=1 for one cycle, then DECODE.
  - DECODE=2: one cycle, no strobes.
    - Known opcode: EXEC.
    - op=0x3F: HALT.
    - Unknown opcode: TRAP.
  - EXEC=3: one cycle.
    - Branch/jump completes here with pc_we=1 and the correct pc_sel, then FETCH.
    - lw/sw go to MEM.
    - R-type/addi/ori/slti go to WB.
  - MEM=4: d_req=1 with d_wr set, held until d_ack. On d_ack:
    - sw: pc_we=1, pc_sel=0, then FETCH.
    - lw: go to WB.
  - WB=5: reg_we=1, pc_we=1, pc_sel=0 for one cycle, then FETCH.
  - HALT=6: sticky. halted=1, no strobes. Only reset exits.
  - TRAP=7: sticky. err=1, no strobes. Only reset exits.
- Decode rules:
  - R-type op=0x00: funct=0x08 is jr (pc_sel=3, no WB); all other functs go to WB with wb_sel=0.
  - lw=0x23, sw=0x2B.
  - beq=0x04: pc_sel=1 if zero, else 0.
  - bne=0x05: pc_sel=1 if !zero, else 0.
  - j=0x02: pc_sel=2.
  - jal=0x03: in EXEC, reg_we=1, wb_sel=2 and pc_we=1, pc_sel=2, all in the same cycle.
  - addi=0x08, ori=0x0D, slti=0x0A: go to WB.
- wb_sel=1 in WB for lw, otherwise 0.
- Latency with no wait states:
  - R-type and I-type ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches and jumps: 3 cycles.
- Exactly one pc_we pulse per retired instruction.
- retired increments on the same cycle as that pc_we pulse, and wraps modulo 2^CNT_W.
- Halt counts as retired on HALT entry, with no pc_we.
- Timeout: a counter resets on entry to FETCH or MEM. Reaching ACK_TIMEOUT cycles without an ack enters TRAP and drops i_req/d_req.
- An ack arriving in a state that did not request it is ignored.
- WE rising outside LOAD: the current instruction completes. Instead of going to FETCH, the FSM enters LOAD.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - pc_sel and wb_sel codes.
- The pure decode (op/funct/zero to class, pc_sel, wb_sel, legal) is one combinational sub-module, mips_ctrl_decode, reused by a future pipelined control unit.

Test Plan:
- Reset with WE=1, then release WE with i_ack tied high:
  - state goes LOAD -> FETCH -> DECODE;
  - all strobes 0 during LOAD.
- Instruction op=0x00, funct=0x20 (add), zero-wait acks:
  - ir_we on cycle 1;
  - reg_we and pc_we together on cycle 4, wb_sel=0;
  - retired=1.
- lw with d_ack delayed 3 cycles:
  - d_req held 4 cycles with d_wr=0;
  - then WB with wb_sel=1;
  - total 8 cycles.
- beq with zero=1, then beq with zero=0:
  - pc_sel=1, then pc_sel=0;
  - each has a single pc_we in EXEC and no reg_we.
- op=0x3F gives halted=1 and retired incremented. op=0x3E gives err=1. Both are sticky until RST pulses low mid-state, which clears everything asynchronously.
- i_ack never asserted:
  - TRAP entered exactly ACK_TIMEOUT=16 cycles after FETCH entry;
  - i_req=0 and err=1 from then on.
